// File: rtl/seconds_time_counter.sv
// BCD hh:mm:ss timekeeper advanced by rising edges of the one-second square wave.
// Optional build macro ALARM_EN adds alarm_hour/alarm_min inputs and the alarm strobe.
module seconds_time_counter #(
    parameter int MAX_HOURS = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] load_hour,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
`ifdef ALARM_EN
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_min,
    output logic       alarm,
`endif
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       sec_pulse,
    output logic       rollover,
    output logic       load_err
);

    // Hour modulus and last legal hour, both expressed in BCD for direct compare.
    localparam logic [7:0] HOUR_LIMIT = 8'(((MAX_HOURS / 10) * 16) + (MAX_HOURS % 10));
    localparam logic [7:0] HOUR_LAST  = 8'((((MAX_HOURS - 1) / 10) * 16) + ((MAX_HOURS - 1) % 10));

    function automatic logic digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Modulo-60 BCD increment; bit 8 is the carry out of 59 -> 00.
    function automatic logic [8:0] bcd_inc60(input logic [7:0] v);
        logic [8:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = {1'b1, 8'h00};
            else                r = {1'b0, 4'(v[7:4] + 4'd1), 4'h0};
        end else begin
            r = {1'b0, v[7:4], 4'(v[3:0] + 4'd1)};
        end
        return r;
    endfunction

    logic       tick_q;
    logic       tick_edge;
    logic       load_valid;
    logic [8:0] sec_step;
    logic [8:0] min_step;
    logic       hour_carry;
    logic       day_wrap;
    logic [7:0] next_sec;
    logic [7:0] next_min;
    logic [7:0] next_hour;

    assign tick_edge = tick_in & ~tick_q;

    assign load_valid = digits_ok(load_sec) && digits_ok(load_min) && digits_ok(load_hour)
                     && (load_sec < 8'h60) && (load_min < 8'h60) && (load_hour < HOUR_LIMIT);

    always_comb begin
        sec_step   = bcd_inc60(sec);
        min_step   = bcd_inc60(min);
        hour_carry = sec_step[8] & min_step[8];
        day_wrap   = 1'b0;
        next_sec   = sec_step[7:0];
        next_min   = sec_step[8] ? min_step[7:0] : min;
        next_hour  = hour;
        if (hour_carry) begin
            if (hour == HOUR_LAST) begin
                next_hour = 8'h00;
                day_wrap  = 1'b1;
            end else if (hour[3:0] == 4'd9) begin
                next_hour = {4'(hour[7:4] + 4'd1), 4'h0};
            end else begin
                next_hour = {hour[7:4], 4'(hour[3:0] + 4'd1)};
            end
        end
    end

    // Load wins over a coincident edge; the edge is consumed because tick_q still advances.
    always_ff @(posedge clk) begin
        tick_q <= tick_in;
        if (rst) begin
            hour      <= 8'h00;
            min       <= 8'h00;
            sec       <= 8'h00;
            sec_pulse <= 1'b0;
            rollover  <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            rollover  <= 1'b0;
            load_err  <= 1'b0;
            if (load) begin
                if (load_valid) begin
                    hour <= load_hour;
                    min  <= load_min;
                    sec  <= load_sec;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick_edge && run) begin
                hour      <= next_hour;
                min       <= next_min;
                sec       <= next_sec;
                sec_pulse <= 1'b1;
                rollover  <= day_wrap;
            end
        end
    end

`ifdef ALARM_EN
    logic alarm_hit;

    assign alarm_hit = ({next_hour, next_min, next_sec} == {alarm_hour, alarm_min, 8'h00});

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm <= 1'b0;
        end else begin
            alarm <= ~load & tick_edge & run & alarm_hit;
        end
    end
`endif

endmodule

// File: tb/tb_seconds_time_counter.sv
// Bench for seconds_time_counter: 24h and 12h instances against a seconds-of-day model.
// Alarm checks are compiled in when ALARM_EN is defined.
module tb_seconds_time_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b1;
    logic       run = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_hour = 8'h00;
    logic [7:0] load_min = 8'h00;
    logic [7:0] load_sec = 8'h00;
`ifdef ALARM_EN
    logic [7:0] alarm_hour = 8'h00;
    logic [7:0] alarm_min = 8'h00;
    logic       al24, al12;
`endif
    logic [7:0] h24, m24, s24, h12, m12, s12;
    logic       sp24, ro24, le24, sp12, ro12, le12;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    seconds_time_counter #(.MAX_HOURS(24)) dut24 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .run(run), .load(load),
        .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
`ifdef ALARM_EN
        .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm(al24),
`endif
        .hour(h24), .min(m24), .sec(s24),
        .sec_pulse(sp24), .rollover(ro24), .load_err(le24)
    );

    seconds_time_counter #(.MAX_HOURS(12)) dut12 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .run(run), .load(load),
        .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
`ifdef ALARM_EN
        .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm(al12),
`endif
        .hour(h12), .min(m12), .sec(s12),
        .sec_pulse(sp12), .rollover(ro12), .load_err(le12)
    );

    // Model: time is an integer count of seconds since midnight.
    int MAXH[2] = '{24, 12};
    int t[2];
    bit m_pulse[2], m_roll[2], m_err[2], m_alarm[2];
    bit m_tick_prev;

    function automatic bit digit_ok(input logic [7:0] v);
        return (int'(v[7:4]) <= 9) && (int'(v[3:0]) <= 9);
    endfunction

    function automatic int bval(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic logic [23:0] hms(input int secs);
        return {to_bcd(secs / 3600), to_bcd((secs / 60) % 60), to_bcd(secs % 60)};
    endfunction

    function automatic bit load_ok(input logic [7:0] h, input logic [7:0] m,
                                   input logic [7:0] s, input int maxh);
        return digit_ok(h) && digit_ok(m) && digit_ok(s)
            && bval(s) < 60 && bval(m) < 60 && bval(h) < maxh;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_pulse[k] = 1'b0;
            m_roll[k]  = 1'b0;
            m_err[k]   = 1'b0;
            m_alarm[k] = 1'b0;
            if (rst) begin
                t[k] = 0;
            end else if (load) begin
                if (load_ok(load_hour, load_min, load_sec, MAXH[k]))
                    t[k] = bval(load_hour) * 3600 + bval(load_min) * 60 + bval(load_sec);
                else
                    m_err[k] = 1'b1;
            end else if (tick_in && !m_tick_prev && run) begin
                t[k]       = (t[k] + 1) % (MAXH[k] * 3600);
                m_pulse[k] = 1'b1;
                m_roll[k]  = (t[k] == 0);
`ifdef ALARM_EN
                m_alarm[k] = (hms(t[k]) == {alarm_hour, alarm_min, 8'h00});
`endif
            end
        end
        m_tick_prev = tick_in;
    end

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("time24", {h24, m24, s24}, hms(t[0]));
            check("time12", {h12, m12, s12}, hms(t[1]));
            check("strobes24", {21'd0, sp24, ro24, le24}, {21'd0, m_pulse[0], m_roll[0], m_err[0]});
            check("strobes12", {21'd0, sp12, ro12, le12}, {21'd0, m_pulse[1], m_roll[1], m_err[1]});
`ifdef ALARM_EN
            check("alarm24", {23'd0, al24}, {23'd0, m_alarm[0]});
            check("alarm12", {23'd0, al12}, {23'd0, m_alarm[1]});
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load_hour = h;
        load_min  = m;
        load_sec  = s;
        load      = 1'b1;
        cyc();
        load      = 1'b0;
    endtask

    function automatic logic [7:0] rand_field(input int maxv);
        if ($urandom_range(0, 7) == 0) return 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 0) return to_bcd(maxv - 1);
        return to_bcd($urandom_range(0, maxv - 1));
    endfunction

    initial begin
        // Reset with tick_in already high: release must not count it.
        cyc();
        check_en = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (3) cyc();
        check("reset_hold_time", {h24, m24, s24}, 24'h000000);
        check("reset_hold_pulse", {23'd0, sp24}, 24'd0);
        tick_in = 1'b0; cyc();
        tick_in = 1'b1; cyc();
        check("first_edge_time", {h24, m24, s24}, 24'h000001);
        check("first_edge_pulse", {23'd0, sp24}, 24'd1);
        cyc();
        check("long_high_no_recount", {h24, m24, s24, 7'd0, sp24}, {24'h000001, 8'd0});
        tick_in = 1'b0; cyc();

        // Day wrap on the 24h instance.
        do_load(8'h23, 8'h59, 8'h58);
        check("load_235958", {h24, m24, s24}, 24'h235958);
        check("load_23_rejected_12h", {23'd0, le12}, 24'd1);
        tick_in = 1'b1; cyc();
        check("to_235959", {h24, m24, s24}, 24'h235959);
        tick_in = 1'b0; cyc();
        tick_in = 1'b1; cyc();
        check("wrap24_time", {h24, m24, s24}, 24'h000000);
        check("wrap24_roll", {22'd0, ro24, sp24}, 24'd3);
        tick_in = 1'b0; cyc();
        check("wrap24_roll_drop", {23'd0, ro24}, 24'd0);

        // 12h wrap; the 24h instance goes to noon without rollover.
        do_load(8'h11, 8'h59, 8'h59);
        tick_in = 1'b1; cyc();
        check("wrap12_time", {h12, m12, s12}, 24'h000000);
        check("wrap12_roll", {23'd0, ro12}, 24'd1);
        check("noon24", {h24, m24, s24, 7'd0, ro24}, {24'h120000, 8'd0});
        tick_in = 1'b0; cyc();

        // Invalid loads leave the time alone.
        do_load(8'h12, 8'h00, 8'h5A);
        check("bad_sec_err", {23'd0, le24}, 24'd1);
        check("bad_sec_time", {h24, m24, s24}, 24'h120000);
        cyc();
        check("bad_sec_err_drop", {23'd0, le24}, 24'd0);
        do_load(8'h24, 8'h00, 8'h00);
        check("bad_hour_err", {23'd0, le24}, 24'd1);
        check("bad_hour_time", {h24, m24, s24}, 24'h120000);

        // Load beats a coincident edge.
        tick_in = 1'b1;
        do_load(8'h10, 8'h20, 8'h30);
        check("load_edge_time", {h24, m24, s24}, 24'h102030);
        check("load_edge_pulse", {23'd0, sp24}, 24'd0);
        tick_in = 1'b0; cyc();

        // Edges while held are dropped, not queued.
        run = 1'b0;
        repeat (5) begin
            tick_in = 1'b1; cyc();
            tick_in = 1'b0; cyc();
        end
        run = 1'b1;
        cyc();
        tick_in = 1'b1; cyc();
        check("hold_then_run", {h24, m24, s24}, 24'h102031);
        tick_in = 1'b0; cyc();

`ifdef ALARM_EN
        alarm_hour = 8'h07;
        alarm_min  = 8'h30;
        do_load(8'h07, 8'h29, 8'h59);
        tick_in = 1'b1; cyc();
        check("alarm_fire", {h24, m24, s24, 7'd0, al24}, {24'h073000, 8'd1});
        tick_in = 1'b0; cyc();
        check("alarm_drop", {23'd0, al24}, 24'd0);
        do_load(8'h07, 8'h30, 8'h00);
        check("alarm_no_load", {23'd0, al24}, 24'd0);
`endif

        // Randomized traffic checked every cycle by the compare process.
        for (int i = 0; i < 6000; i++) begin
            rst  = ($urandom_range(0, 799) == 0);
            run  = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1) == 1) tick_in = ~tick_in;
            if (load) begin
                load_hour = rand_field($urandom_range(0, 1) == 1 ? 24 : 12);
                load_min  = rand_field(60);
                load_sec  = to_bcd(50 + $urandom_range(0, 9));
                if ($urandom_range(0, 7) == 0) load_sec = 8'($urandom_range(0, 255));
`ifdef ALARM_EN
                alarm_hour = to_bcd((bval(load_hour) + $urandom_range(0, 1)) % 24);
                alarm_min  = to_bcd((bval(load_min) + 1) % 60);
`endif
            end
            cyc();
        end
        rst  = 1'b0;
        load = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seconds_time_counter.md
# seconds_time_counter

Timekeeping stage directly downstream of the one-second period pulse generator. Consumes that generator's toggling square wave, detects one rising edge per second, and advances a BCD hours:minutes:seconds counter. Supports run/hold, synchronous time load, and one-cycle strobes for display and sequencing logic further downstream.

## Interface
Parameters:
- MAX_HOURS, 24: hour modulus; legal values are 12 or 24. The hour counter wraps from MAX_HOURS-1 to 0.

Ports:
- clk  in  1  system clock; sole clock of the block.
- rst  in  1  synchronous, active-high reset.
- tick_in  in  1  square wave from the one-second pulse generator; each rising edge is one counted second.
- run  in  1  1 = count on tick edges; 0 = hold time, edges ignored.
- load  in  1  one-cycle strobe that loads load_hour/load_min/load_sec.
- load_hour  in  8  BCD hour {tens, units}.
- load_min  in  8  BCD minute.
- load_sec  in  8  BCD second.
- hour  out  8  BCD hours; reset 8'h00.
- min  out  8  BCD minutes; reset 8'h00.
- sec  out  8  BCD seconds; reset 8'h00.
- sec_pulse  out  1  one-cycle strobe per counted second; reset 0.
- rollover  out  1  one-cycle strobe on wrap to 00:00:00; reset 0.
- load_err  out  1  one-cycle strobe when a load is rejected; reset 0.
- alarm  out  1  exists only with ALARM_EN; see Configuration; reset 0.
- alarm_hour, alarm_min  in  8 each  exist only with ALARM_EN.

## Operation
- Edge detect: a registered copy tick_q holds tick_in from the previous cycle. edge = tick_in & ~tick_q.
- Priority on each clock edge, highest first:
  - rst: clear all outputs and counters. Set tick_q <= tick_in, so a tick_in that is already high at reset release is not counted.
  - load: validate the load value and load it, or reject it (rules below). No increment occurs this cycle, even if edge=1 and run=1; that edge is discarded.
  - edge & run: increment the time.
  - Otherwise: hold.
- Load validation: every BCD digit must be ≤9, sec < 0x60, min < 0x60, and hour < MAX_HOURS (in BCD).
  - If the load is invalid, the time is unchanged and load_err pulses for 1 cycle.
- Increment is a BCD cascade:
  - sec units 9→0 carries into sec tens.
  - sec 59→00 carries into min; min 59→00 carries into hour.
  - hour (MAX_HOURS-1)→00 asserts rollover.
- sec_pulse is asserted on every increment cycle. It is not asserted on load or hold.
- run=0 ignores edges; they are not queued. On return to run=1, counting resumes at the next new rising edge.
- Internal digits never hold a non-BCD value.

## Timing
- Latency: if edge is sampled at clock edge k, the new time and sec_pulse are visible after edge k. sec_pulse and rollover drop after edge k+1.
- Load: load sampled at edge k puts the new value on the outputs after edge k. load_err has the same timing.
- rollover is coincident with the sec_pulse of the 23:59:59→00:00:00 increment (11:59:59 when MAX_HOURS=12).
- A tick_in high for many cycles yields exactly one increment. The block requires tick_in low for ≥1 cycle between edges.
- Reset asserted mid-count takes effect at the next clk edge. There is no partial cascade.

## Configuration
- ALARM_EN: compiles in the alarm_hour and alarm_min ports and the alarm output.
  - With ALARM_EN defined: alarm pulses for 1 cycle on the increment that makes {hour, min, sec} == {alarm_hour, alarm_min, 8'h00}. Loads never trigger alarm. Alarm timing matches sec_pulse.
  - Without ALARM_EN: the ports and the comparator are absent, and all other behaviour is identical.

## Test plan
- Reset with tick_in held 1, then release rst: no increment. Time stays 00:00:00 until tick_in goes 0 then 1, then sec=8'h01 with a single sec_pulse.
- Load 23:59:58, then give 2 edges with run=1: reads 23:59:59, then 00:00:00 with rollover=1 for exactly 1 cycle. With MAX_HOURS=12, load 11:59:59, give 1 edge: reads 00:00:00 with rollover.
- Load sec=8'h5A, then load hour=8'h24 with MAX_HOURS=24: each load pulses load_err and the time is unchanged.
- Drive load and an edge in the same cycle with load value 10:20:30: result is 10:20:30 and sec_pulse=0.
- Set run=0, give 5 edges, then run=1 and 1 edge: time advances by exactly 1 second.
- ALARM_EN: set alarm 07:30, load 07:29:59, give 1 edge: alarm=1 for 1 cycle at 07:30:00. Loading 07:30:00 directly gives alarm=0.
